// File: rtl/pic16_tmr0.sv
// PIC16-style Timer0 with OPTION register, T0CKI synchronizer/edge detect,
// programmable prescaler, post-write increment inhibit and sticky overflow flag.
module pic16_tmr0 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WE,
  input  logic [8:0] EA,
  input  logic [7:0] WDATA,
  input  logic       T0CKI,
  input  logic       T0IF_CLR,
  output logic [7:0] RDATA,
  output logic       HIT,
  output logic       T0IF,
  output logic [7:0] OPTION_Q
);

  logic [7:0] r_tmr0;
  logic [7:0] r_option;
  logic [7:0] r_psc;
  logic [1:0] r_inhibit;
  logic       r_t0if;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;

  logic       w_sel_tmr0;
  logic       w_sel_opt;
  logic       w_wr_tmr0;
  logic       w_wr_opt;
  logic       w_t0cs;
  logic       w_t0se;
  logic       w_psa;
  logic [2:0] w_ps;
  logic       w_edge;
  logic       w_src;
  logic       w_tick;
  logic [7:0] w_psc_max;
  logic       w_psc_tc;
  logic       w_inc;
  logic       w_ovf;

  // Bank bit EA[8] is ignored: both registers are mirrored in the upper bank.
  assign w_sel_tmr0 = (EA[7:0] == 8'h01);
  assign w_sel_opt  = (EA[7:0] == 8'h81);
  assign w_wr_tmr0  = WE & w_sel_tmr0;
  assign w_wr_opt   = WE & w_sel_opt;

  assign w_t0cs = r_option[5];
  assign w_t0se = r_option[4];
  assign w_psa  = r_option[3];
  assign w_ps   = r_option[2:0];

  // An edge needs sync2 != sync3, so a polarity or source switch cannot fake one.
  assign w_edge = w_t0se ? (r_sync3 & ~r_sync2) : (r_sync2 & ~r_sync3);
  assign w_src  = w_t0cs ? w_edge : 1'b1;
  assign w_tick = w_src & (r_inhibit == 2'd0);

  assign w_psc_max = 8'((9'd2 << w_ps) - 9'd1);
  assign w_psc_tc  = (r_psc == w_psc_max);
  assign w_inc     = w_tick & (w_psa | w_psc_tc);
  assign w_ovf     = w_inc & (r_tmr0 == 8'hFF) & ~w_wr_tmr0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tmr0    <= 8'h00;
      r_option  <= 8'hFF;
      r_psc     <= 8'h00;
      r_inhibit <= 2'd0;
      r_t0if    <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
    end else begin
      r_sync1 <= T0CKI;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      if (w_wr_opt)
        r_option <= WDATA;

      if (w_wr_tmr0) begin
        r_tmr0    <= WDATA;
        r_inhibit <= 2'd2;
      end else begin
        if (r_inhibit != 2'd0)
          r_inhibit <= r_inhibit - 2'd1;
        if (w_inc)
          r_tmr0 <= r_tmr0 + 8'd1;
      end

      if (w_wr_tmr0 || w_wr_opt || w_psa)
        r_psc <= 8'h00;
      else if (w_tick)
        r_psc <= w_psc_tc ? 8'h00 : r_psc + 8'd1;

      if (w_ovf)
        r_t0if <= 1'b1;
      else if (T0IF_CLR)
        r_t0if <= 1'b0;
    end
  end

  always_comb begin
    RDATA = 8'h00;
    if (w_sel_tmr0)
      RDATA = r_tmr0;
    else if (w_sel_opt)
      RDATA = r_option;
  end

  assign HIT      = w_sel_tmr0 | w_sel_opt;
  assign T0IF     = r_t0if;
  assign OPTION_Q = r_option;

endmodule
